dram_cmd_scheduler: RTL and testbench
=====================================

# dram_cmd_scheduler

Open-page command scheduler between the address-translation/address-buffer stage and the bank/row/column decoders. It accepts one translated request at a time and tracks the open row of every bank. It emits the ACT/READ/WRITE/PRE sequence that request needs, with fixed tRCD/tRP spacing, and inserts refresh (PREA + REF, tRFC) when the refresh counter flags it.

## Interface
- NUM_OF_BANKS, 8, bank count; BW = $clog2(NUM_OF_BANKS)
- NUM_OF_ROWS, 128, rows per bank; RW_ = $clog2(NUM_OF_ROWS)
- NUM_OF_COLS, 8, columns per row; CW = $clog2(NUM_OF_COLS)
- T_RCD, 2, cycles from ACT to READ/WRITE (>=1)
- T_RP, 2, cycles from PRE/PREA to the next ACT/REF (>=1)
- T_RFC, 8, cycles from REF to refresh_ack (>=1)

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  translated request present
- req_ready  out  1  scheduler can accept; = (state==IDLE) && !ref_pending
- req_bank  in  BW  target bank
- req_row  in  RW_  target row
- req_col  in  CW  target column
- req_we  in  1  1 = write, 0 = read
- refresh_req  in  1  one-cycle pulse from the refresh counter
- refresh_ack  out  1  one-cycle pulse when a refresh completes
- cmd  out  3  000 NOP, 001 ACT, 010 READ, 011 WRITE, 100 PRE, 101 PREA, 110 REF; registered
- cmd_bank  out  BW  bank for ACT/READ/WRITE/PRE; registered
- cmd_row  out  RW_  row for ACT; registered
- cmd_col  out  CW  column for READ/WRITE; registered
- busy  out  1  state != IDLE

## Operation
- Open-row table: per bank one open bit plus RW_ bits of row. Cleared on rst and on PREA. Set on ACT. Cleared per bank on PRE.
- A request is accepted when req_valid && req_ready at a rising edge. bank/row/col/we are latched at that edge.
- Classification at acceptance:
  - HIT: bank open, same row.
  - CLOSED: bank not open.
  - CONFLICT: bank open, different row.
- FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RW, REF_PREA, REF_PREA_WAIT, REF, REF_WAIT.
- IDLE transitions:
  - ref_pending → REF_PREA if any bank is open, else REF.
  - Otherwise, accepted HIT → RW, CLOSED → ACT, CONFLICT → PRE.
- Request path:
  - PRE issues PRE, then PRE_WAIT, then ACT.
  - ACT issues ACT, then ACT_WAIT, then RW.
  - RW issues READ or WRITE per latched we, then IDLE.
- Refresh path:
  - REF_PREA issues PREA, then REF_PREA_WAIT, then REF.
  - REF issues REF, then REF_WAIT.
  - At the end of REF_WAIT, refresh_ack pulses and the FSM returns to IDLE.
- Wait-state counters:
  - Loaded with (T_x − 1) when the command issues.
  - Decrement to 0, then advance.
  - When T_x == 1, the wait state is skipped.
- ref_pending:
  - Set by refresh_req in any state.
  - Cleared when REF issues.
  - Pulses arriving while it is already set merge; there is no count.
- Priority: refresh beats a new request at IDLE. A request already accepted always completes before refresh starts.
- cmd is NOP in every state/cycle not listed above. cmd_bank/row/col hold their last value during NOP.

## Timing
- Reset values: cmd=NOP, cmd_bank/row/col=0, refresh_ack=0, busy=0, req_ready=1 after the first post-reset edge. Open table is cleared, ref_pending=0, state=IDLE.
- rst asserted mid-sequence: the sequence is abandoned immediately and cmd=NOP the next cycle. A refresh_req on the same edge as rst is dropped.
- Accept at edge E (cycle 0 = the cycle after E). Latencies:
  - HIT: READ/WRITE in cycle 0.
  - CLOSED: ACT in cycle 0, READ/WRITE in cycle T_RCD.
  - CONFLICT: PRE in cycle 0, ACT in cycle T_RP, READ/WRITE in cycle T_RP+T_RCD.
- req_ready goes high the cycle after READ/WRITE. Back-to-back HITs therefore issue one command every 2 cycles.
- Refresh from IDLE with banks open: PREA in cycle 0, REF in cycle T_RP, refresh_ack in cycle T_RP+T_RFC, req_ready high the cycle after.
- Refresh from IDLE with all banks closed: REF in cycle 0.
- refresh_req and req_valid in the same IDLE cycle: req_ready is already low only if ref_pending was set. The request is accepted if ready was high that cycle, and refresh follows once the request finishes.

## Test plan
- After rst, req bank 3, row 5, col 2, read → ACT b3 r5 in cycle 0, READ b3 c2 in cycle 2; table shows b3 open at r5.
- Then req b3, r5, c7, write → WRITE b3 c7 in cycle 0, with no ACT or PRE issued.
- Then req b3, r9, c1, read → PRE b3 in cycle 0, ACT b3 r9 in cycle 2, READ b3 c1 in cycle 4.
- refresh_req pulsed twice during the CONFLICT sequence → after READ, PREA, then REF 2 cycles later, then a single refresh_ack 8 cycles after REF. req_ready stays low throughout. The next req to b3 r9 is treated as CLOSED (ACT issued).
- refresh_req with all banks closed → REF in cycle 0, refresh_ack in cycle 8, no PREA.
- rst asserted the cycle after ACT of a CLOSED request → no READ issued, cmd=NOP, table cleared, req_ready=1 after release.

Source files
------------

// File: rtl/dram_cmd_scheduler_if.sv
// Request handshake from the address stage and command bus toward the bank/row/column decoders.
// The scheduler connects through the slave modport and the request source through the master modport.
interface dram_cmd_scheduler_if #(
  parameter int BW  = 3,
  parameter int RW_ = 7,
  parameter int CW  = 3
);
  logic           req_valid;
  logic           req_ready;
  logic [BW-1:0]  req_bank;
  logic [RW_-1:0] req_row;
  logic [CW-1:0]  req_col;
  logic           req_we;
  logic [2:0]     cmd;
  logic [BW-1:0]  cmd_bank;
  logic [RW_-1:0] cmd_row;
  logic [CW-1:0]  cmd_col;

  modport master (
    output req_valid, req_bank, req_row, req_col, req_we,
    input  req_ready, cmd, cmd_bank, cmd_row, cmd_col
  );

  modport slave (
    input  req_valid, req_bank, req_row, req_col, req_we,
    output req_ready, cmd, cmd_bank, cmd_row, cmd_col
  );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Open-page DRAM command scheduler: tracks the open row per bank and issues
// ACT/READ/WRITE/PRE with fixed tRCD/tRP spacing, plus PREA/REF refresh with tRFC.
module dram_cmd_scheduler #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  dram_cmd_scheduler_if.slave bus,
  input  logic                i_refresh_req,
  output logic                o_refresh_ack,
  output logic                o_busy
);
  localparam int BW   = $clog2(NUM_OF_BANKS);
  localparam int RW_  = $clog2(NUM_OF_ROWS);
  localparam int CW   = $clog2(NUM_OF_COLS);
  localparam int CNTW = 16;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_ACT   = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;
  localparam logic [2:0] CMD_PRE   = 3'b100;
  localparam logic [2:0] CMD_PREA  = 3'b101;
  localparam logic [2:0] CMD_REF   = 3'b110;

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_PRE           = 4'd1,
    S_PRE_WAIT      = 4'd2,
    S_ACT           = 4'd3,
    S_ACT_WAIT      = 4'd4,
    S_RW            = 4'd5,
    S_REF_PREA      = 4'd6,
    S_REF_PREA_WAIT = 4'd7,
    S_REF           = 4'd8,
    S_REF_WAIT      = 4'd9
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNTW-1:0]           r_cnt;
  logic [NUM_OF_BANKS-1:0]   r_open;
  logic [RW_-1:0]            r_open_row [NUM_OF_BANKS];
  logic [BW-1:0]             r_bank;
  logic [RW_-1:0]            r_row;
  logic [CW-1:0]             r_col;
  logic                      r_we;
  logic                      r_ref_pending;
  logic [2:0]                r_cmd;
  logic [BW-1:0]             r_cmd_bank;
  logic [RW_-1:0]            r_cmd_row;
  logic [CW-1:0]             r_cmd_col;
  logic                      r_ack;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_hit;
  logic                      w_any_open;
  logic                      w_cnt_zero;
  logic [BW-1:0]             w_bank_src;
  logic [RW_-1:0]            w_row_src;
  logic [CW-1:0]             w_col_src;
  logic                      w_we_src;
  logic [2:0]                w_cmd_nxt;
  logic [BW-1:0]             w_cmd_bank_nxt;
  logic [RW_-1:0]            w_cmd_row_nxt;
  logic [CW-1:0]             w_cmd_col_nxt;
  logic                      w_ack_nxt;

  assign w_ready    = (r_state == S_IDLE) && !r_ref_pending;
  assign w_accept   = bus.req_valid && w_ready;
  assign w_hit      = r_open[bus.req_bank] && (r_open_row[bus.req_bank] == bus.req_row);
  assign w_any_open = |r_open;
  assign w_cnt_zero = (r_cnt == {CNTW{1'b0}});

  // A HIT issues on the accept edge itself, so in IDLE the live request fields are used.
  assign w_bank_src = (r_state == S_IDLE) ? bus.req_bank : r_bank;
  assign w_row_src  = (r_state == S_IDLE) ? bus.req_row  : r_row;
  assign w_col_src  = (r_state == S_IDLE) ? bus.req_col  : r_col;
  assign w_we_src   = (r_state == S_IDLE) ? bus.req_we   : r_we;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_ref_pending) begin
          w_state_nxt = w_any_open ? S_REF_PREA : S_REF;
        end else if (w_accept) begin
          if (w_hit) begin
            w_state_nxt = S_RW;
          end else begin
            w_state_nxt = r_open[bus.req_bank] ? S_PRE : S_ACT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRE, S_PRE_WAIT:           w_state_nxt = w_cnt_zero ? S_ACT : S_PRE_WAIT;
      S_ACT, S_ACT_WAIT:           w_state_nxt = w_cnt_zero ? S_RW  : S_ACT_WAIT;
      S_RW:                        w_state_nxt = S_IDLE;
      S_REF_PREA, S_REF_PREA_WAIT: w_state_nxt = w_cnt_zero ? S_REF : S_REF_PREA_WAIT;
      S_REF, S_REF_WAIT:           w_state_nxt = w_cnt_zero ? S_IDLE : S_REF_WAIT;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // Command for the state being entered; address fields hold unless the command uses them
  always_comb begin
    w_cmd_nxt      = CMD_NOP;
    w_cmd_bank_nxt = r_cmd_bank;
    w_cmd_row_nxt  = r_cmd_row;
    w_cmd_col_nxt  = r_cmd_col;
    case (w_state_nxt)
      S_PRE: begin
        w_cmd_nxt      = CMD_PRE;
        w_cmd_bank_nxt = w_bank_src;
      end
      S_ACT: begin
        w_cmd_nxt      = CMD_ACT;
        w_cmd_bank_nxt = w_bank_src;
        w_cmd_row_nxt  = w_row_src;
      end
      S_RW: begin
        w_cmd_nxt      = w_we_src ? CMD_WRITE : CMD_READ;
        w_cmd_bank_nxt = w_bank_src;
        w_cmd_col_nxt  = w_col_src;
      end
      S_REF_PREA: w_cmd_nxt = CMD_PREA;
      S_REF:      w_cmd_nxt = CMD_REF;
      default:    w_cmd_nxt = CMD_NOP;
    endcase
    w_ack_nxt = ((r_state == S_REF) || (r_state == S_REF_WAIT)) && w_cnt_zero;
  end

  // Registered command bus and refresh acknowledge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd      <= CMD_NOP;
      r_cmd_bank <= {BW{1'b0}};
      r_cmd_row  <= {RW_{1'b0}};
      r_cmd_col  <= {CW{1'b0}};
      r_ack      <= 1'b0;
    end else begin
      r_cmd      <= w_cmd_nxt;
      r_cmd_bank <= w_cmd_bank_nxt;
      r_cmd_row  <= w_cmd_row_nxt;
      r_cmd_col  <= w_cmd_col_nxt;
      r_ack      <= w_ack_nxt;
    end
  end

  // Spacing counter: loaded with T-1 as a command issues, then counts down to zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {CNTW{1'b0}};
    end else begin
      case (w_state_nxt)
        S_PRE, S_REF_PREA: r_cnt <= CNTW'(T_RP - 1);
        S_ACT:             r_cnt <= CNTW'(T_RCD - 1);
        S_REF:             r_cnt <= CNTW'(T_RFC - 1);
        default: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNTW'(1);
          end else begin
            r_cnt <= r_cnt;
          end
        end
      endcase
    end
  end

  // Open-row table, latched request and refresh-pending flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_open        <= {NUM_OF_BANKS{1'b0}};
      r_bank        <= {BW{1'b0}};
      r_row         <= {RW_{1'b0}};
      r_col         <= {CW{1'b0}};
      r_we          <= 1'b0;
      r_ref_pending <= 1'b0;
      for (int i = 0; i < NUM_OF_BANKS; i++) begin
        r_open_row[i] <= {RW_{1'b0}};
      end
    end else begin
      if (w_state_nxt == S_REF_PREA) begin
        r_open <= {NUM_OF_BANKS{1'b0}};
      end else if (w_state_nxt == S_ACT) begin
        r_open[w_bank_src]     <= 1'b1;
        r_open_row[w_bank_src] <= w_row_src;
      end else if (w_state_nxt == S_PRE) begin
        r_open[w_bank_src] <= 1'b0;
      end else begin
        r_open <= r_open;
      end
      if (w_accept) begin
        r_bank <= bus.req_bank;
        r_row  <= bus.req_row;
        r_col  <= bus.req_col;
        r_we   <= bus.req_we;
      end
      // A new pulse on the REF edge wins so that it is not lost.
      if (i_refresh_req) begin
        r_ref_pending <= 1'b1;
      end else if (w_state_nxt == S_REF) begin
        r_ref_pending <= 1'b0;
      end else begin
        r_ref_pending <= r_ref_pending;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.cmd       = r_cmd;
  assign bus.cmd_bank  = r_cmd_bank;
  assign bus.cmd_row   = r_cmd_row;
  assign bus.cmd_col   = r_cmd_col;
  assign o_refresh_ack = r_ack;
  assign o_busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: directed vector table, a hand-written refresh/request
// collision sequence, and random traffic against a command-timeline reference model.
module tb_dram_cmd_scheduler;
  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int TRFC = 8;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_ACT  = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_PREA = 3'd5;
  localparam logic [2:0] C_REF  = 3'd6;

  logic clk = 1'b0;
  logic rst;
  logic rf;
  logic ack;
  logic busy;

  dram_cmd_scheduler_if #(.BW(3), .RW_(7), .CW(3)) bus ();

  dram_cmd_scheduler #(
    .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8),
    .T_RCD(TRCD), .T_RP(TRP), .T_RFC(TRFC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .i_refresh_req(rf), .o_refresh_ack(ack), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic drive(input bit r, input bit v, input logic [2:0] b, input logic [6:0] rw,
                       input logic [2:0] c, input bit we, input bit f);
    rst = r; bus.req_valid = v; bus.req_bank = b; bus.req_row = rw;
    bus.req_col = c; bus.req_we = we; rf = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r; bit v; logic [2:0] b; logic [6:0] rw; logic [2:0] c; bit we; bit f;
    logic [2:0] ecmd; logic [2:0] eb; logic [6:0] er; logic [2:0] ec;
    bit erdy; bit eack; bit ebusy; bit crdy;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, bit v, logic [2:0] b, logic [6:0] rw, logic [2:0] c, bit we, bit f,
                              logic [2:0] ecmd, logic [2:0] eb, logic [6:0] er, logic [2:0] ec,
                              bit erdy, bit eack, bit ebusy, bit crdy);
    vec_t t;
    t = '{r, v, b, rw, c, we, f, ecmd, eb, er, ec, erdy, eack, ebusy, crdy};
    tbl.push_back(t);
  endfunction

  // ---------------- reference model: queue of expected per-cycle outputs ----------------
  typedef struct { logic [2:0] cmd; logic [2:0] b; logic [6:0] r; logic [2:0] c; bit ack; bit busy; } ent_t;
  ent_t       q[$];
  bit         m_pend;
  bit         m_open [8];
  logic [6:0] m_row  [8];
  logic [2:0] e_cmd, e_b, e_c;
  logic [6:0] e_r;
  bit         e_ack, e_busy;

  function automatic void push(logic [2:0] cmd, logic [2:0] b, logic [6:0] r, logic [2:0] c, bit a, bit bz);
    ent_t e;
    e = '{cmd, b, r, c, a, bz};
    q.push_back(e);
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [2:0] b, input logic [6:0] rw,
                            input logic [2:0] c, input bit we, input bit f);
    ent_t n;
    bit   rdy;
    bit   any;
    rdy = !e_busy && !m_pend;
    if (r) begin
      q.delete();
      m_pend = 1'b0;
      for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
      e_cmd = C_NOP; e_b = 3'd0; e_r = 7'd0; e_c = 3'd0; e_ack = 1'b0; e_busy = 1'b0;
    end else begin
      if (!e_busy && q.size() == 0) begin
        if (m_pend) begin
          any = 1'b0;
          for (int i = 0; i < 8; i++) any |= m_open[i];
          if (any) begin
            push(C_PREA, 3'd0, 7'd0, 3'd0, 1'b0, 1'b1);
            repeat (TRP - 1) push(C_NOP, 3'd0, 7'd0, 3'd0, 1'b0, 1'b1);
            for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
          end
          push(C_REF, 3'd0, 7'd0, 3'd0, 1'b0, 1'b1);
          repeat (TRFC - 1) push(C_NOP, 3'd0, 7'd0, 3'd0, 1'b0, 1'b1);
          push(C_NOP, 3'd0, 7'd0, 3'd0, 1'b1, 1'b0);
        end else if (v && rdy) begin
          if (!(m_open[b] && m_row[b] == rw)) begin
            if (m_open[b]) begin
              push(C_PRE, b, 7'd0, 3'd0, 1'b0, 1'b1);
              repeat (TRP - 1) push(C_NOP, 3'd0, 7'd0, 3'd0, 1'b0, 1'b1);
            end
            push(C_ACT, b, rw, 3'd0, 1'b0, 1'b1);
            repeat (TRCD - 1) push(C_NOP, 3'd0, 7'd0, 3'd0, 1'b0, 1'b1);
            m_open[b] = 1'b1;
            m_row[b]  = rw;
          end
          push(we ? C_WR : C_RD, b, 7'd0, c, 1'b0, 1'b1);
        end
      end
      if (q.size() > 0) n = q.pop_front();
      else n = '{C_NOP, 3'd0, 7'd0, 3'd0, 1'b0, 1'b0};
      e_cmd = n.cmd; e_ack = n.ack; e_busy = n.busy;
      case (n.cmd)
        C_ACT:       begin e_b = n.b; e_r = n.r; end
        C_RD, C_WR:  begin e_b = n.b; e_c = n.c; end
        C_PRE:       e_b = n.b;
        default:     ;
      endcase
      if (n.cmd == C_REF) m_pend = 1'b0;
      if (f) m_pend = 1'b1;
    end
  endtask

  task automatic cmp_model(input int n);
    chk($sformatf("rnd%0d_cmd", n),   bus.cmd,       e_cmd);
    chk($sformatf("rnd%0d_bank", n),  bus.cmd_bank,  e_b);
    chk($sformatf("rnd%0d_row", n),   bus.cmd_row,   e_r);
    chk($sformatf("rnd%0d_col", n),   bus.cmd_col,   e_c);
    chk($sformatf("rnd%0d_ack", n),   ack,           e_ack);
    chk($sformatf("rnd%0d_busy", n),  busy,          e_busy);
    chk($sformatf("rnd%0d_ready", n), bus.req_ready, !e_busy && !m_pend);
  endtask

  initial begin
    int found;
    int lat;
    bit r, v, we, f;
    logic [2:0] b, c;
    logic [6:0] rw;

    // reset, CLOSED read, HIT write, CONFLICT read with two refresh pulses
    add(1,0,0,0,0,0,0, C_NOP,0,0,0, 1,0,0,1);
    add(0,1,3,5,2,0,0, C_ACT,3,5,0, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,3,5,0, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_RD, 3,5,2, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,3,5,2, 1,0,0,1);
    add(0,1,3,5,7,1,0, C_WR, 3,5,7, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,3,5,7, 1,0,0,1);
    add(0,1,3,9,1,0,0, C_PRE,3,5,7, 0,0,1,1);
    add(0,0,0,0,0,0,1, C_NOP,3,5,7, 0,0,1,1);
    add(0,0,0,0,0,0,1, C_ACT,3,9,7, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,3,9,7, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_RD, 3,9,1, 0,0,1,1);
    add(0,1,3,9,0,0,0, C_NOP,3,9,1, 0,0,0,1);
    add(0,1,3,9,0,0,0, C_PREA,3,9,1, 0,0,1,1);
    add(0,1,3,9,0,0,0, C_NOP,3,9,1, 0,0,1,1);
    add(0,1,3,9,0,0,0, C_REF,3,9,1, 0,0,1,1);
    for (int i = 0; i < TRFC - 1; i++) add(0,1,3,9,0,0,0, C_NOP,3,9,1, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,3,9,1, 0,1,0,0);
    add(0,0,0,0,0,0,0, C_NOP,3,9,1, 1,0,0,1);
    add(0,1,3,9,0,0,0, C_ACT,3,9,1, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,3,9,1, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_RD, 3,9,0, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,3,9,0, 1,0,0,1);
    // refresh with every bank closed
    add(1,0,0,0,0,0,0, C_NOP,0,0,0, 1,0,0,1);
    add(0,0,0,0,0,0,1, C_NOP,0,0,0, 0,0,0,1);
    add(0,0,0,0,0,0,0, C_REF,0,0,0, 0,0,1,1);
    for (int i = 0; i < TRFC - 1; i++) add(0,0,0,0,0,0,0, C_NOP,0,0,0, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,0,0,0, 0,1,0,0);
    add(0,0,0,0,0,0,0, C_NOP,0,0,0, 1,0,0,1);
    // reset right after ACT, then the same bank must be CLOSED again
    add(0,1,2,4,3,0,0, C_ACT,2,4,0, 0,0,1,1);
    add(1,0,0,0,0,0,0, C_NOP,0,0,0, 1,0,0,1);
    add(0,0,0,0,0,0,0, C_NOP,0,0,0, 1,0,0,1);
    add(0,1,2,4,5,0,0, C_ACT,2,4,0, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,2,4,0, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_RD, 2,4,5, 0,0,1,1);
    add(0,0,0,0,0,0,0, C_NOP,2,4,5, 1,0,0,1);
    // refresh pulse coinciding with reset is dropped
    add(1,0,0,0,0,0,1, C_NOP,0,0,0, 1,0,0,1);
    add(0,0,0,0,0,0,0, C_NOP,0,0,0, 1,0,0,1);
    add(0,0,0,0,0,0,0, C_NOP,0,0,0, 1,0,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].rw, tbl[i].c, tbl[i].we, tbl[i].f);
      tick();
      chk($sformatf("v%0d_cmd", i),  bus.cmd,      tbl[i].ecmd);
      chk($sformatf("v%0d_bank", i), bus.cmd_bank, tbl[i].eb);
      chk($sformatf("v%0d_row", i),  bus.cmd_row,  tbl[i].er);
      chk($sformatf("v%0d_col", i),  bus.cmd_col,  tbl[i].ec);
      chk($sformatf("v%0d_ack", i),  ack,          tbl[i].eack);
      chk($sformatf("v%0d_busy", i), busy,         tbl[i].ebusy);
      if (tbl[i].crdy) chk($sformatf("v%0d_ready", i), bus.req_ready, tbl[i].erdy);
    end

    // HIT accepted in the same cycle as a refresh pulse; refresh follows the write
    drive(0,1,3'd5,7'd6,3'd1,0,0); tick();
    chk("h_act", bus.cmd, C_ACT); chk("h_act_bank", bus.cmd_bank, 5);
    drive(0,0,3'd0,7'd0,3'd0,0,0); tick(); tick();
    chk("h_rd", bus.cmd, C_RD); chk("h_rd_col", bus.cmd_col, 1);
    tick();
    chk("h_idle_ready", bus.req_ready, 1);
    drive(0,1,3'd5,7'd6,3'd4,1,1); tick();
    chk("h_wr", bus.cmd, C_WR); chk("h_wr_col", bus.cmd_col, 4);
    drive(0,0,3'd0,7'd0,3'd0,0,0); tick();
    chk("h_pend_ready", bus.req_ready, 0); chk("h_pend_busy", busy, 0);
    found = 0;
    for (int k = 0; k < 4 && found == 0; k++) begin
      tick();
      if (bus.cmd == C_PREA) found = 1;
    end
    chk("h_prea_seen", found, 1);
    repeat (TRP) tick();
    chk("h_ref", bus.cmd, C_REF);
    found = 0; lat = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      tick();
      if (ack) begin found = 1; lat = k; end
    end
    chk("h_ack_seen", found, 1); chk("h_ack_lat", lat, TRFC);
    tick();
    chk("h_ack_single", ack, 0); chk("h_ready_after", bus.req_ready, 1);

    // random traffic against the reference model
    drive(1,0,3'd0,7'd0,3'd0,0,0);
    model_edge(1,0,3'd0,7'd0,3'd0,0,0);
    tick();
    cmp_model(-1);
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      v  = $urandom_range(0, 1);
      b  = 3'($urandom_range(0, 3));
      rw = 7'($urandom_range(0, 2));
      c  = 3'($urandom_range(0, 7));
      we = $urandom_range(0, 1);
      f  = ($urandom_range(0, 49) == 0);
      if (e_ack) begin
        v = 1'b0;
        f = 1'b0;
      end
      model_edge(r, v, b, rw, c, we, f);
      drive(r, v, b, rw, c, we, f);
      tick();
      cmp_model(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
